// File: rtl/dot11_scrambler_pair.sv
// 802.11-style scrambler/descrambler pair, generator polynomial x^7 + x^4 + 1.
// Both lanes share clock, reset, enable and reseed control. Outputs are combinational
// from the held LFSR state.
// Optional feature macro: SELF_SYNC_EN. When defined, both lanes are multiplicative
// (self-synchronising). When undefined, both lanes are additive.
module dot11_scrambler_pair #(
    parameter logic [6:0] SEED = 7'h7F
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [6:0] seed_in,
    input  logic       bit_in,
    output logic       bit_out,
    input  logic       rx_bit_in,
    output logic       rx_bit_out,
    output logic [6:0] state_out,
    output logic [6:0] destate_out
);

    // An all-zero seed would lock the LFSR, so it is replaced by all-ones.
    localparam logic [6:0] SeedEff = (SEED == 7'h00) ? 7'h7F : SEED;

    logic [6:0] s_q, s_d;
    logic [6:0] d_q, d_d;
    logic [6:0] load_val;
    logic       fs, fd;

    // Feedback taps, zero-latency outputs and next-state selection.
    always_comb begin
        fs         = s_q[6] ^ s_q[3];
        fd         = d_q[6] ^ d_q[3];
        bit_out    = bit_in ^ fs;
        rx_bit_out = rx_bit_in ^ fd;
        load_val   = (seed_in == 7'h00) ? 7'h7F : seed_in;
        s_d        = s_q;
        d_d        = d_q;
        if (load) begin
            s_d = load_val;
            d_d = load_val;
        end else if (enable) begin
`ifdef SELF_SYNC_EN
            s_d = {s_q[5:0], bit_out};
            d_d = {d_q[5:0], rx_bit_in};
`else
            s_d = {s_q[5:0], fs};
            d_d = {d_q[5:0], fd};
`endif
        end
    end

    // LFSR state registers; reset forces both lanes to the seed immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s_q <= SeedEff;
            d_q <= SeedEff;
        end else begin
            s_q <= s_d;
            d_q <= d_d;
        end
    end

    assign state_out   = s_q;
    assign destate_out = d_q;

endmodule

// File: tb/tb_dot11_scrambler_pair.sv
// Directed, table-driven bench for dot11_scrambler_pair.
module tb_dot11_scrambler_pair;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       load;
    logic [6:0] seed_in;
    logic       bit_in;
    logic       bit_out;
    logic       rx_tb;
    logic       lb;
    logic       rx_bit_in;
    logic       rx_bit_out;
    logic [6:0] state_out;
    logic [6:0] destate_out;

    int total = 0;
    int bad   = 0;

    assign rx_bit_in = lb ? bit_out : rx_tb;

    always #5 clock = ~clock;

    dot11_scrambler_pair #(.SEED(7'h7F)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
        .seed_in     (seed_in),
        .bit_in      (bit_in),
        .bit_out     (bit_out),
        .rx_bit_in   (rx_bit_in),
        .rx_bit_out  (rx_bit_out),
        .state_out   (state_out),
        .destate_out (destate_out)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       ld;
        logic       en;
        logic [6:0] seed;
        logic       bi;
        logic       exp_bo;
        logic       exp_fs;
        logic [6:0] exp_st;
    } vec_t;

    vec_t vt [13];

    initial begin
        logic [6:0] held_s;
        logic       held_b;
        logic [7:0] fs_seq;

        vt[0]  = '{1'b0, 1'b1, 7'h00, 1'b1, 1'b1, 1'b0, 7'h7E};
        vt[1]  = '{1'b0, 1'b1, 7'h00, 1'b1, 1'b1, 1'b0, 7'h7C};
        vt[2]  = '{1'b0, 1'b1, 7'h00, 1'b1, 1'b1, 1'b0, 7'h78};
        vt[3]  = '{1'b0, 1'b1, 7'h00, 1'b1, 1'b1, 1'b0, 7'h70};
        vt[4]  = '{1'b0, 1'b1, 7'h00, 1'b1, 1'b0, 1'b1, 7'h61};
        vt[5]  = '{1'b0, 1'b1, 7'h00, 1'b1, 1'b0, 1'b1, 7'h43};
        vt[6]  = '{1'b0, 1'b1, 7'h00, 1'b1, 1'b0, 1'b1, 7'h07};
        vt[7]  = '{1'b0, 1'b1, 7'h00, 1'b1, 1'b1, 1'b0, 7'h0E};
        vt[8]  = '{1'b1, 1'b0, 7'h55, 1'b0, 1'b1, 1'b1, 7'h55};
        vt[9]  = '{1'b1, 1'b1, 7'h00, 1'b1, 1'b0, 1'b1, 7'h7F};
        vt[10] = '{1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 7'h7F};
        vt[11] = '{1'b1, 1'b1, 7'h55, 1'b0, 1'b0, 1'b0, 7'h55};
        vt[12] = '{1'b0, 1'b1, 7'h00, 1'b0, 1'b1, 1'b1, 7'h2B};

        reset   = 1'b0;
        enable  = 1'b0;
        load    = 1'b0;
        seed_in = 7'h00;
        bit_in  = 1'b0;
        rx_tb   = 1'b0;
        lb      = 1'b0;

        // Reset hold.
        repeat (10) @(posedge clock);
        #1;
        chk("reset_state", state_out, 7'h7F);
        chk("reset_destate", destate_out, 7'h7F);

        @(negedge clock);
        reset = 1'b1;

`ifndef SELF_SYNC_EN
        // Vector table: first 8 enabled bits, then reseed cases.
        for (int i = 0; i < 13; i++) begin
            load    = vt[i].ld;
            enable  = vt[i].en;
            seed_in = vt[i].seed;
            bit_in  = vt[i].bi;
            rx_tb   = 1'b0;
            #1;
            chk($sformatf("vec%0d_bit_out", i), bit_out, vt[i].exp_bo);
            chk($sformatf("vec%0d_rx_bit_out", i), rx_bit_out, vt[i].exp_fs);
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d_state", i), state_out, vt[i].exp_st);
            chk($sformatf("vec%0d_destate", i), destate_out, vt[i].exp_st);
            @(negedge clock);
        end

        // Loopback from seed 7F for 200 cycles.
        load    = 1'b1;
        seed_in = 7'h7F;
        enable  = 1'b0;
        @(negedge clock);
        load   = 1'b0;
        enable = 1'b1;
        bit_in = 1'b1;
        lb     = 1'b1;
        for (int i = 0; i < 200; i++) begin
            #1;
            chk("loop_rx_bit_out", rx_bit_out, 1);
            chk("loop_states_equal", destate_out, state_out);
            @(negedge clock);
        end
        lb = 1'b0;

        // Period: 127 enabled steps return to the seed.
        enable  = 1'b0;
        load    = 1'b1;
        seed_in = 7'h7F;
        @(negedge clock);
        load   = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 126; i++) begin
            @(negedge clock);
            if (i == 0) chk("period_moved", (state_out != 7'h7F), 1);
        end
        chk("period_not_early", (state_out != 7'h7F), 1);
        @(negedge clock);
        chk("period_127", state_out, 7'h7F);

        // Hold with enable low.
        enable = 1'b0;
        bit_in = 1'b1;
        @(negedge clock);
        held_s = state_out;
        held_b = bit_out;
        chk("hold_start", held_s, 7'h7F);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("hold_state", state_out, held_s);
            chk("hold_bit_out", bit_out, held_b);
        end

        // Async reset mid-stream after 50 enabled cycles.
        enable = 1'b1;
        bit_in = 1'b0;
        repeat (50) @(negedge clock);
        chk("mid_not_seed", (state_out != 7'h7F), 1);
        reset = 1'b0;
        #1;
        chk("async_state", state_out, 7'h7F);
        chk("async_destate", destate_out, 7'h7F);
        #1;
        reset = 1'b1;
        fs_seq = 8'b0111_0000;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("restart_fs%0d", i), bit_out, fs_seq[i]);
            @(negedge clock);
        end
`else
        // Self-synchronising loopback with random plaintext.
        enable = 1'b1;
        lb     = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bit_in = 1'($urandom_range(0, 1));
            #1;
            if (i >= 7) chk("selfsync_rx", rx_bit_out, bit_in);
            @(negedge clock);
        end
        lb      = 1'b0;
        enable  = 1'b0;
        load    = 1'b1;
        seed_in = 7'h55;
        @(posedge clock);
        #1;
        chk("selfsync_load_s", state_out, 7'h55);
        chk("selfsync_load_d", destate_out, 7'h55);
        load    = 1'b0;
        seed_in = 7'h00;
        reset   = 1'b0;
        #1;
        chk("selfsync_reset", state_out, 7'h7F);
        reset = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
